s2p_fifo_push: RTL and testbench

Serial-to-parallel front end that feeds the parameterised FIFO from a one-bit serial stream; it is the receive-side counterpart of the FIFO-pop / serialiser path. It reassembles LSB-first serial bits into FIFO_WIDTH-bit words and checks word framing. It pushes each complete word into the FIFO, back-pressuring the serial source while the FIFO is full. It optionally accumulates words within a packet of NUM_LOOPS words (ADD_MODE).

---
 rtl/s2p_fifo_push_if.sv | 27 ++
 rtl/s2p_fifo_push.sv | 147 ++++++++++++++
 tb/tb_s2p_fifo_push.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_fifo_push_if.sv
// Handshake bundle between the serial source / FIFO side and s2p_fifo_push.
// The slave view belongs to the serial-to-parallel block; the master view
// belongs to whatever drives the serial stream and reports FIFO fullness.
interface s2p_fifo_push_if #(
    parameter int FIFO_WIDTH = 8
);
    logic                  ser_valid;
    logic                  ser_data;
    logic                  ser_last;
    logic                  ser_ready;
    logic                  push;
    logic [FIFO_WIDTH-1:0] push_data;
    logic                  full;
    logic                  pkt_done;
    logic                  frame_err;
    logic [7:0]            err_cnt;

    modport slave (
        input  ser_valid, ser_data, ser_last, full,
        output ser_ready, push, push_data, pkt_done, frame_err, err_cnt
    );

    modport master (
        output ser_valid, ser_data, ser_last, full,
        input  ser_ready, push, push_data, pkt_done, frame_err, err_cnt
    );
endinterface

// File: rtl/s2p_fifo_push.sv
// Serial-to-parallel FIFO push front end.
// Collects LSB-first serial bits into FIFO_WIDTH-bit words, checks that
// ser_last marks exactly the final bit, and pushes each good word into the
// FIFO, stalling the serial source while the FIFO is full. With ADD_MODE set,
// the pushed value is the running sum of the words in the current packet of
// NUM_LOOPS words.
module s2p_fifo_push #(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_LOOPS  = 3,
    parameter int ADD_MODE   = 0
) (
    input  logic            clk,
    input  logic            rstn,
    s2p_fifo_push_if.slave  bus
);

    localparam int IDX_W = $clog2(FIFO_WIDTH);
    localparam int WRD_W = $clog2(NUM_LOOPS);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FIFO_WIDTH - 1);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(NUM_LOOPS - 1);

    typedef enum logic {
        SHIFT = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [IDX_W-1:0]      bit_idx;
    logic [WRD_W-1:0]      word_idx;
    // Only the lower FIFO_WIDTH-1 bits are stored; the top bit of a word is
    // taken straight from ser_data on the accepting edge.
    logic [FIFO_WIDTH-2:0] shreg;
    logic [FIFO_WIDTH-1:0] acc;
    logic [FIFO_WIDTH-1:0] push_data_r;
    logic                  frame_err_r;
    logic [7:0]            err_cnt_r;

    logic                  ready;
    logic                  accept;
    logic                  good_word;
    logic                  bad_word;
    logic                  push_fire;
    logic                  pkt_end;
    logic [FIFO_WIDTH-1:0] word;

    // Modulo-2^FIFO_WIDTH accumulation; the carry out is deliberately dropped.
    function automatic logic [FIFO_WIDTH-1:0] wrap_add(
        input logic [FIFO_WIDTH-1:0] a,
        input logic [FIFO_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // Error counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign word = {bus.ser_data, shreg};

    // Next-state and handshake decode; everything is forced idle while rstn is low.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        good_word = 1'b0;
        bad_word  = 1'b0;
        push_fire = 1'b0;
        pkt_end   = 1'b0;
        case (state)
            SHIFT: begin
                ready  = rstn;
                accept = rstn && bus.ser_valid;
                if (accept) begin
                    if (bit_idx == LAST_BIT) begin
                        good_word = bus.ser_last;
                        bad_word  = !bus.ser_last;
                    end else begin
                        bad_word  = bus.ser_last;
                    end
                end
                if (good_word) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                push_fire = rstn && !bus.full;
                pkt_end   = push_fire && (word_idx == LAST_WORD);
                if (push_fire) begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = SHIFT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    // Word assembly, framing check, output word and packet accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_idx     <= '0;
            word_idx    <= '0;
            shreg       <= '0;
            acc         <= '0;
            push_data_r <= '0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            frame_err_r <= bad_word;
            if (bad_word) begin
                // Partial word is dropped; stale shreg bits are overwritten
                // before they can ever reach push_data.
                bit_idx   <= '0;
                err_cnt_r <= sat_inc(err_cnt_r);
            end else if (good_word) begin
                push_data_r <= (ADD_MODE != 0) ? wrap_add(word, acc) : word;
                bit_idx     <= '0;
            end else if (accept) begin
                shreg[bit_idx] <= bus.ser_data;
                bit_idx        <= bit_idx + IDX_W'(1);
            end

            if (push_fire) begin
                acc      <= pkt_end ? '0 : push_data_r;
                word_idx <= pkt_end ? '0 : word_idx + WRD_W'(1);
            end
        end
    end

    assign bus.ser_ready = ready;
    assign bus.push      = push_fire;
    assign bus.pkt_done  = pkt_end;
    assign bus.push_data = push_data_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_s2p_fifo_push.sv
// Testbench for s2p_fifo_push: one raw-mode and one add-mode instance share
// the same stimulus; a queue-based reference model predicts every output.
module tb_s2p_fifo_push;

    localparam int W  = 8;
    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic sv, sd, sl, sfull;

    s2p_fifo_push_if #(.FIFO_WIDTH(W)) bus0 ();
    s2p_fifo_push_if #(.FIFO_WIDTH(W)) bus1 ();

    assign bus0.ser_valid = sv;
    assign bus0.ser_data  = sd;
    assign bus0.ser_last  = sl;
    assign bus0.full      = sfull;
    assign bus1.ser_valid = sv;
    assign bus1.ser_data  = sd;
    assign bus1.ser_last  = sl;
    assign bus1.full      = sfull;

    s2p_fifo_push #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .ADD_MODE(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0.slave));
    s2p_fifo_push #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .ADD_MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1.slave));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: collected bits, pending word, packet position, errors.
    bit mq[$];
    bit m_hold;
    int m_pd0, m_pd1, m_acc, m_words, m_ec;
    bit m_fe;

    // Values observed in the most recent step.
    logic       o_push0, o_push1, o_pkt0, o_pkt1, o_fe0, o_fe1;
    logic [7:0] o_pd0, o_pd1, o_ec0, o_ec1;

    typedef struct {
        logic [7:0] word;
        int         stall;
        logic [7:0] exp0;
        logic [7:0] exp1;
        bit         exp_pkt;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_hold = 0; m_pd0 = 0; m_pd1 = 0; m_acc = 0; m_words = 0; m_ec = 0; m_fe = 0;
    endtask

    task automatic model_error();
        mq.delete();
        m_fe = 1;
        m_ec = (m_ec >= 255) ? 255 : m_ec + 1;
    endtask

    // Drive one cycle of inputs, check all outputs, advance the model one edge.
    task automatic step(input bit v, input bit d, input bit l, input bit f);
        bit ex_ready, ex_push, ex_pkt, pkt;
        int w;
        sv = v; sd = d; sl = l; sfull = f;
        #1;
        ex_ready = rstn && !m_hold;
        ex_push  = rstn && m_hold && !f;
        ex_pkt   = ex_push && (m_words == NL - 1);
        chk("ready0", bus0.ser_ready, ex_ready);
        chk("ready1", bus1.ser_ready, ex_ready);
        chk("push0", bus0.push, ex_push);
        chk("push1", bus1.push, ex_push);
        chk("pkt0", bus0.pkt_done, ex_pkt);
        chk("pkt1", bus1.pkt_done, ex_pkt);
        chk("pdata0", bus0.push_data, m_pd0);
        chk("pdata1", bus1.push_data, m_pd1);
        chk("ferr0", bus0.frame_err, m_fe);
        chk("ferr1", bus1.frame_err, m_fe);
        chk("ecnt0", bus0.err_cnt, m_ec);
        chk("ecnt1", bus1.err_cnt, m_ec);
        o_push0 = bus0.push;      o_push1 = bus1.push;
        o_pkt0  = bus0.pkt_done;  o_pkt1  = bus1.pkt_done;
        o_pd0   = bus0.push_data; o_pd1   = bus1.push_data;
        o_fe0   = bus0.frame_err; o_fe1   = bus1.frame_err;
        o_ec0   = bus0.err_cnt;   o_ec1   = bus1.err_cnt;

        if (!rstn) begin
            model_clear();
        end else begin
            m_fe = 0;
            if (m_hold) begin
                if (!f) begin
                    pkt     = (m_words == NL - 1);
                    m_acc   = pkt ? 0 : m_pd1;
                    m_words = pkt ? 0 : m_words + 1;
                    m_hold  = 0;
                end
            end else if (v) begin
                if (mq.size() == W - 1) begin
                    if (l) begin
                        w = 0;
                        for (int i = 0; i < W - 1; i++) w += int'(mq[i]) << i;
                        w += int'(d) << (W - 1);
                        m_pd0  = w;
                        m_pd1  = (w + m_acc) % (1 << W);
                        m_hold = 1;
                        mq.delete();
                    end else begin
                        model_error();
                    end
                end else if (l) begin
                    model_error();
                end else begin
                    mq.push_back(d);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        repeat (n) step(0, 0, 0, 0);
        rstn = 1'b1;
    endtask

    // Full word, stall cycles with full=1, then the push cycle with full=0.
    task automatic send_word(input logic [7:0] w, input int stall);
        for (int i = 0; i < W; i++) step(1, w[i], i == W - 1, 0);
        repeat (stall) step(1, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] wv;
        bit v, d, l, f;

        tbl[0] = '{8'h10, 0, 8'h10, 8'h10, 1'b0};
        tbl[1] = '{8'h20, 0, 8'h20, 8'h30, 1'b0};
        tbl[2] = '{8'hF0, 0, 8'hF0, 8'h20, 1'b1};
        tbl[3] = '{8'h05, 0, 8'h05, 8'h05, 1'b0};
        tbl[4] = '{8'hA5, 0, 8'hA5, 8'hAA, 1'b0};
        tbl[5] = '{8'h3C, 5, 8'h3C, 8'hE6, 1'b1};
        tbl[6] = '{8'h81, 0, 8'h81, 8'h81, 1'b0};

        rstn = 1'b0; sv = 0; sd = 0; sl = 0; sfull = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset(2);

        // Table-driven words: raw and accumulated push values, packet end, stall.
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].word, tbl[i].stall);
            chk("tbl_push", o_push0, 1'b1);
            chk("tbl_pdata0", o_pd0, tbl[i].exp0);
            chk("tbl_pdata1", o_pd1, tbl[i].exp1);
            chk("tbl_pkt", o_pkt1, tbl[i].exp_pkt);
            chk("tbl_ferr", o_fe0, 1'b0);
        end

        // Early ser_last on bit 3, then a clean word.
        do_reset(1);
        wv = 8'h0B;
        for (int i = 0; i < 3; i++) step(1, wv[i], 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        chk("early_ferr", o_fe0, 1'b1);
        chk("early_ecnt", o_ec0, 8'd1);
        chk("early_nopush", o_push0, 1'b0);
        send_word(8'h81, 0);
        chk("after_err_push", o_push0, 1'b1);
        chk("after_err_pdata1", o_pd1, 8'h81);

        // Missing ser_last on bit 7, repeated until the counter saturates.
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < W; i++) step(1, 1'($urandom_range(0, 1)), 0, 0);
        end
        step(0, 0, 0, 0);
        chk("sat_ferr", o_fe0, 1'b1);
        chk("sat_ecnt", o_ec1, 8'd255);
        chk("sat_nopush", o_push1, 1'b0);

        // Reset after 5 bits discards the partial word.
        wv = 8'hFF;
        for (int i = 0; i < 5; i++) step(1, wv[i], 0, 0);
        do_reset(1);
        chk("rst_ecnt", o_ec0, 8'd255);
        send_word(8'h5A, 0);
        chk("rst_mid_pdata1", o_pd1, 8'h5A);
        chk("rst_mid_pkt", o_pkt1, 1'b0);

        // Reset while holding a word: no push, then a fresh 3-word packet.
        wv = 8'h77;
        for (int i = 0; i < W; i++) step(1, wv[i], i == W - 1, 0);
        rstn = 1'b0;
        step(0, 0, 0, 0);
        rstn = 1'b1;
        chk("rst_hold_nopush", o_push0, 1'b0);
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        chk("rst_hold_pkt", o_pkt1, 1'b1);
        chk("rst_hold_sum", o_pd1, 8'h06);

        // Randomized traffic with gaps, back-pressure, framing errors and resets.
        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 19) == 0) ? (mq.size() != W - 1) : (mq.size() == W - 1);
            f = ($urandom_range(0, 9) < 3);
            rstn = ($urandom_range(0, 99) != 0);
            step(v, d, l, f);
        end
        rstn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
